// File: rtl/cw_bus_arbiter_pkg.sv
// Shared types and constants for the CW external-bus arbiter slice.
package cw_bus_pkg;

   localparam int CW_ADDR_W = 24;
   localparam int CW_DATA_W = 16;
   localparam int CW_BL_W   = 3;

   // Owner indices: instruction fetch and data-cache fill/write-back.
   localparam int M_IFETCH = 0;
   localparam int M_DATA   = 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/cw_bus_arbiter_if.sv
// One CW bus link: a master drives the request, a slave returns the response.
interface cw_bus_arbiter_if;
   import cw_bus_pkg::*;

   logic                 cyc;
   logic                 stb;
   logic                 we;
   logic [CW_ADDR_W-1:0] adr;
   logic [CW_BL_W-1:0]   bl;
   logic [CW_DATA_W-1:0] dat_w;
   logic [CW_DATA_W-1:0] dat_r;
   logic                 ack;
   logic                 err;

   modport master (output cyc, stb, we, adr, bl, dat_w, input dat_r, ack, err);
   modport slave  (input cyc, stb, we, adr, bl, dat_w, output dat_r, ack, err);

endinterface

// File: rtl/cw_bus_arbiter_watchdog.sv
// Stall watchdog: down-counter reloaded on clr, terminal count gives expired.
module cw_arb_watchdog #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] remain;

   // Count down one per stalled cycle; hold at zero until cleared.
   always_ff @(posedge i_clk) begin
      if (i_rst || clr) remain <= RELOAD;
      else if (en && remain != '0) remain <= remain - 1'b1;
   end

   assign expired = en && (remain == '0);

endmodule

// File: rtl/cw_bus_arbiter.sv
// Two-master round-robin arbiter in front of the CW pin serializer.
// Optional stall watchdog enabled by defining CW_ARB_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no owner, serializer cyc/stb low, picks next owner
// ST_GRANT | owner's request forwarded, serializer response routed back
module cw_bus_arbiter
   import cw_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   cw_bus_arbiter_if.slave         m0,
   cw_bus_arbiter_if.slave         m1,
   cw_bus_arbiter_if.master        s,
   output logic [1:0]              o_owner
);
   arb_state_t state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic [1:0] hold_q, hold_d;
   logic [1:0] req;
   logic       own_cyc, own_stb;
   logic       wd_expired;
   logic       resp_ack, resp_err;

   // A master that timed out is ignored until it lets go of cyc.
   assign req     = {m1.cyc & ~hold_q[1], m0.cyc & ~hold_q[0]};
   assign own_cyc = owner_q ? m1.cyc : m0.cyc;
   assign own_stb = owner_q ? m1.stb : m0.stb;

`ifdef CW_ARB_TIMEOUT_EN
   logic wd_en, wd_clr;
   assign wd_en  = (state_q == ST_GRANT) && own_cyc && own_stb && !s.ack && !s.err;
   assign wd_clr = (state_q != ST_GRANT) || s.ack || s.err;

   cw_arb_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
   assign wd_expired     = 1'b0;
`endif

   // State, owner, round-robin pointer and timeout hold-off registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         owner_q <= 1'(M_IFETCH);
         last_q  <= 1'(M_DATA);
         hold_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state: grant on any request, release when owner drops cyc or times out.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      hold_d  = hold_q & {m1.cyc, m0.cyc};
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               state_d = ST_GRANT;
               owner_d = (req == 2'b11) ? ~last_q : req[1];
            end
         end
         ST_GRANT: begin
            if (!own_cyc || wd_expired) begin
               state_d = ST_IDLE;
               last_d  = owner_q;
               if (wd_expired) hold_d[owner_q] = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output mux: forward the owner's request, route the response to it only.
   always_comb begin
      s.cyc    = 1'b0;
      s.stb    = 1'b0;
      s.we     = 1'b0;
      s.adr    = '0;
      s.bl     = '0;
      s.dat_w  = '0;
      m0.ack   = 1'b0;
      m0.err   = 1'b0;
      m0.dat_r = '0;
      m1.ack   = 1'b0;
      m1.err   = 1'b0;
      m1.dat_r = '0;
      o_owner  = 2'b00;
      resp_err = s.err | wd_expired;
      resp_ack = s.ack & ~resp_err;
      if (state_q == ST_GRANT) begin
         o_owner = owner_q ? 2'b10 : 2'b01;
         s.cyc   = own_cyc & ~wd_expired;
         s.stb   = own_stb & ~wd_expired;
         if (owner_q) begin
            s.we     = m1.we;
            s.adr    = m1.adr;
            s.bl     = m1.bl;
            s.dat_w  = m1.dat_w;
            m1.ack   = resp_ack;
            m1.err   = resp_err;
            m1.dat_r = s.dat_r;
         end else begin
            s.we     = m0.we;
            s.adr    = m0.adr;
            s.bl     = m0.bl;
            s.dat_w  = m0.dat_w;
            m0.ack   = resp_ack;
            m0.err   = resp_err;
            m0.dat_r = s.dat_r;
         end
      end
   end

endmodule

// File: tb/tb_cw_bus_arbiter.sv
// Directed bench for cw_bus_arbiter: per-cycle vector table plus
// hand-written round-robin and watchdog sequences.
module tb_cw_bus_arbiter;

   typedef struct packed {
      logic        cyc, stb, we;
      logic [23:0] adr;
      logic [2:0]  bl;
      logic [15:0] dat;
   } mreq_t;

   typedef struct packed {
      logic [1:0]  owner;
      logic        s_cyc, s_stb, s_we;
      logic [23:0] s_adr;
      logic [2:0]  s_bl;
      logic [15:0] s_dat;
      logic        m0_ack, m0_err;
      logic [15:0] m0_dat;
      logic        m1_ack, m1_err;
      logic [15:0] m1_dat;
   } out_t;

   typedef struct {
      logic        rst;
      mreq_t       m0, m1;
      logic        s_ack, s_err;
      logic [15:0] s_dat;
      out_t        exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] owner;
   int         n_vec = 0;
   int         n_err = 0;
   vec_t       tbl[$];

   cw_bus_arbiter_if m0_if ();
   cw_bus_arbiter_if m1_if ();
   cw_bus_arbiter_if s_if ();

   cw_bus_arbiter #(.TIMEOUT(16)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .m0      (m0_if),
      .m1      (m1_if),
      .s       (s_if),
      .o_owner (owner)
   );

   always #5 clk = ~clk;

   function automatic mreq_t mr(logic c, logic st, logic w, logic [23:0] a, logic [2:0] b, logic [15:0] d);
      mreq_t r;
      r.cyc = c; r.stb = st; r.we = w; r.adr = a; r.bl = b; r.dat = d;
      return r;
   endfunction

   function automatic out_t ex(logic [1:0] o, mreq_t f, logic a0, logic e0, logic [15:0] d0,
                               logic a1, logic e1, logic [15:0] d1);
      out_t x;
      x.owner = o; x.s_cyc = f.cyc; x.s_stb = f.stb; x.s_we = f.we;
      x.s_adr = f.adr; x.s_bl = f.bl; x.s_dat = f.dat;
      x.m0_ack = a0; x.m0_err = e0; x.m0_dat = d0;
      x.m1_ack = a1; x.m1_err = e1; x.m1_dat = d1;
      return x;
   endfunction

   function automatic out_t sample();
      out_t x;
      x.owner = owner; x.s_cyc = s_if.cyc; x.s_stb = s_if.stb; x.s_we = s_if.we;
      x.s_adr = s_if.adr; x.s_bl = s_if.bl; x.s_dat = s_if.dat_w;
      x.m0_ack = m0_if.ack; x.m0_err = m0_if.err; x.m0_dat = m0_if.dat_r;
      x.m1_ack = m1_if.ack; x.m1_err = m1_if.err; x.m1_dat = m1_if.dat_r;
      return x;
   endfunction

   task automatic add(logic r, mreq_t a, mreq_t b, logic ak, logic er, logic [15:0] sd, out_t e);
      vec_t v;
      v.rst = r; v.m0 = a; v.m1 = b; v.s_ack = ak; v.s_err = er; v.s_dat = sd; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic drive_m(int idx, mreq_t r);
      if (idx == 0) begin
         m0_if.cyc = r.cyc; m0_if.stb = r.stb; m0_if.we = r.we;
         m0_if.adr = r.adr; m0_if.bl = r.bl; m0_if.dat_w = r.dat;
      end else begin
         m1_if.cyc = r.cyc; m1_if.stb = r.stb; m1_if.we = r.we;
         m1_if.adr = r.adr; m1_if.bl = r.bl; m1_if.dat_w = r.dat;
      end
   endtask

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      mreq_t z, f, a0, w1, l1, p0, rq;
      out_t  idle;
      int    hit, nerr_pulse, cur;

      z    = '0;
      f    = mr(1, 1, 0, 24'hffe000, 3'd2, 16'h0000);
      a0   = mr(1, 1, 0, 24'h000123, 3'd0, 16'h0000);
      w1   = mr(1, 1, 1, 24'h100080, 3'd0, 16'hf8e2);
      l1   = mr(1, 1, 0, 24'h200000, 3'd2, 16'h0000);
      p0   = mr(1, 1, 0, 24'h000040, 3'd0, 16'h0000);
      idle = ex(2'b00, z, 0, 0, 16'h0, 0, 0, 16'h0);

      // single 4-beat fetch, then release and a stray ack in idle
      add(0, f, z, 0, 0, 16'h0000, idle);
      add(0, f, z, 1, 0, 16'h000e, ex(2'b01, f, 1, 0, 16'h000e, 0, 0, 16'h0));
      add(0, f, z, 1, 0, 16'h0100, ex(2'b01, f, 1, 0, 16'h0100, 0, 0, 16'h0));
      add(0, f, z, 1, 0, 16'h0000, ex(2'b01, f, 1, 0, 16'h0000, 0, 0, 16'h0));
      add(0, f, z, 1, 0, 16'h0000, ex(2'b01, f, 1, 0, 16'h0000, 0, 0, 16'h0));
      add(0, z, z, 0, 0, 16'h0000, ex(2'b01, z, 0, 0, 16'h0, 0, 0, 16'h0));
      add(0, z, z, 1, 0, 16'h1234, idle);
      // contention after reset: m0 first, one idle cycle, then m1 write
      add(1, z, z, 0, 0, 16'h0000, idle);
      add(0, a0, w1, 0, 0, 16'h0000, idle);
      add(0, a0, w1, 1, 0, 16'h5555, ex(2'b01, a0, 1, 0, 16'h5555, 0, 0, 16'h0));
      add(0, z, w1, 0, 0, 16'h0000, ex(2'b01, z, 0, 0, 16'h0, 0, 0, 16'h0));
      add(0, z, w1, 0, 0, 16'h0000, idle);
      add(0, z, w1, 1, 0, 16'h0777, ex(2'b10, w1, 0, 0, 16'h0, 1, 0, 16'h0777));
      add(0, z, z, 0, 0, 16'h0000, ex(2'b10, z, 0, 0, 16'h0, 0, 0, 16'h0));
      add(0, z, z, 0, 0, 16'h0000, idle);
      // burst lock: m1 line fill while m0 requests
      add(0, z, l1, 0, 0, 16'h0000, idle);
      for (int i = 0; i < 4; i++)
         add(0, p0, l1, 1, 0, 16'ha0a0, ex(2'b10, l1, 0, 0, 16'h0, 1, 0, 16'ha0a0));
      add(0, p0, z, 0, 0, 16'h0000, ex(2'b10, z, 0, 0, 16'h0, 0, 0, 16'h0));
      add(0, p0, z, 0, 0, 16'h0000, idle);
      // err beats ack, then reset mid-transfer
      add(0, p0, z, 1, 1, 16'h0bad, ex(2'b01, p0, 0, 1, 16'h0bad, 0, 0, 16'h0));
      add(1, p0, z, 1, 0, 16'h1111, ex(2'b01, p0, 1, 0, 16'h1111, 0, 0, 16'h0));
      add(0, p0, z, 1, 0, 16'h2222, idle);
      add(0, z, z, 0, 0, 16'h0000, ex(2'b01, z, 0, 0, 16'h0, 0, 0, 16'h0));
      add(0, z, z, 0, 0, 16'h0000, idle);

      drive_m(0, z); drive_m(1, z);
      s_if.ack = 0; s_if.err = 0; s_if.dat_r = 16'h0;
      repeat (3) @(negedge clk);

      foreach (tbl[i]) begin
         rst = tbl[i].rst;
         drive_m(0, tbl[i].m0); drive_m(1, tbl[i].m1);
         s_if.ack = tbl[i].s_ack; s_if.err = tbl[i].s_err; s_if.dat_r = tbl[i].s_dat;
         #1;
         chk($sformatf("vec%0d", i), 128'(sample()), 128'(tbl[i].exp));
         @(negedge clk);
      end

      // round-robin: both masters keep coming back after each single beat
      rst = 1; drive_m(0, z); drive_m(1, z);
      s_if.ack = 0; s_if.err = 0; s_if.dat_r = 16'h0;
      @(negedge clk);
      rst = 0;
      rq = mr(1, 1, 0, 24'h000010, 3'd0, 16'h0);
      drive_m(0, rq); drive_m(1, rq);
      for (int t = 0; t < 6; t++) begin
         hit = 0;
         for (int k = 0; k < 5 && hit == 0; k++) begin
            @(negedge clk); #1;
            if (owner != 2'b00) hit = 1;
         end
         chk($sformatf("rr_owner%0d", t), 128'(owner), (t % 2 == 0) ? 128'h1 : 128'h2);
         cur = (owner == 2'b10) ? 1 : 0;
         s_if.ack = 1; #1;
         chk($sformatf("rr_other_ack%0d", t), 128'(cur ? m0_if.ack : m1_if.ack), 128'h0);
         @(negedge clk);
         s_if.ack = 0;
         drive_m(cur, z);
         @(negedge clk);
         drive_m(cur, rq);
      end
      @(negedge clk);
      drive_m(0, z); drive_m(1, z);

      // watchdog: m0 strobes into a silent serializer
      rst = 1;
      @(negedge clk);
      rst = 0;
      drive_m(0, mr(1, 1, 0, 24'h0abcde, 3'd0, 16'h0));
`ifdef CW_ARB_TIMEOUT_EN
      hit = 0; nerr_pulse = 0; cur = 1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk); #1;
         if (m0_if.err) begin
            nerr_pulse++;
            if (hit == 0) begin hit = k; cur = s_if.cyc; end
         end
      end
      chk("wd_cycle", 128'(hit), 128'd16);
      chk("wd_scyc_drop", 128'(cur), 128'h0);
      chk("wd_single_pulse", 128'(nerr_pulse), 128'd1);
      chk("wd_holdoff", 128'(owner), 128'h0);
      drive_m(0, z);
      @(negedge clk);
      drive_m(0, mr(1, 1, 0, 24'h0abcde, 3'd0, 16'h0));
      @(negedge clk); #1;
      chk("wd_regrant", 128'(owner), 128'h1);
`else
      nerr_pulse = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk); #1;
         if (m0_if.err) nerr_pulse++;
      end
      chk("nowd_no_err", 128'(nerr_pulse), 128'd0);
      chk("nowd_stall_owner", 128'(owner), 128'h1);
      chk("nowd_stall_scyc", 128'(s_if.cyc), 128'h1);
`endif
      drive_m(0, z);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
